// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and load-type codes for the MIPS pipeline
package mips_pkg;

   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;

   typedef enum logic [2:0] {
      LD_NONE = 3'b000,
      LB      = 3'b001,
      LBU     = 3'b010,
      LH      = 3'b011,
      LHU     = 3'b100,
      LW      = 3'b101
   } ld_op_e;

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - combinational load data extraction and extension
module load_extract
   import mips_pkg::*;
(
   input  logic [2:0]        ld_op,
   input  logic [DATA_W-1:0] res,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (res[1:0])
         2'd0:    byte_sel = ld_data[7:0];
         2'd1:    byte_sel = ld_data[15:8];
         2'd2:    byte_sel = ld_data[23:16];
         default: byte_sel = ld_data[31:24];
      endcase
      // res[0] is ignored for halfwords; misaligned accesses never get here
      half_sel = res[1] ? ld_data[31:16] : ld_data[15:0];
   end

   always_comb begin
      case (ld_op)
         LB:      result = {{24{byte_sel[7]}}, byte_sel};
         LBU:     result = {24'd0, byte_sel};
         LH:      result = {{16{half_sel[15]}}, half_sel};
         LHU:     result = {16'd0, half_sel};
         LW:      result = ld_data;
         default: result = res;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: pipeline register, load extraction,
// register-file write port, bypass and debug trace
module wb_stage
   import mips_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ms_to_ws_valid,
   output logic                 ws_allowin,
   input  logic [DATA_W-1:0]    ms_pc,
   input  logic                 ms_gr_we,
   input  logic [REG_IDX_W-1:0] ms_dest,
   input  logic [DATA_W-1:0]    ms_res,
   input  logic [2:0]           ms_ld_op,
   input  logic [DATA_W-1:0]    ms_ld_data,
   input  logic                 trace_stall,
   output logic                 rf_we,
   output logic [REG_IDX_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]    rf_wdata,
   output logic [REG_IDX_W-1:0] ws_fwd_dest,
   output logic [DATA_W-1:0]    ws_fwd_data,
   output logic [DATA_W-1:0]    debug_wb_pc,
   output logic [3:0]           debug_wb_rf_wen,
   output logic [REG_IDX_W-1:0] debug_wb_rf_wnum,
   output logic [DATA_W-1:0]    debug_wb_rf_wdata
);

   logic                 ws_valid;
   logic                 ws_ready_go;
   logic [DATA_W-1:0]    ws_pc;
   logic                 ws_gr_we;
   logic [REG_IDX_W-1:0] ws_dest;
   logic [DATA_W-1:0]    ws_res;
   logic [2:0]           ws_ld_op;
   logic [DATA_W-1:0]    ws_ld_data;
   logic [DATA_W-1:0]    ws_result;

   assign ws_ready_go = !trace_stall;
   assign ws_allowin  = !ws_valid || ws_ready_go;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ws_valid   <= 1'b0;
         ws_pc      <= '0;
         ws_gr_we   <= 1'b0;
         ws_dest    <= '0;
         ws_res     <= '0;
         ws_ld_op   <= '0;
         ws_ld_data <= '0;
      end else begin
         if (ws_allowin)
            ws_valid <= ms_to_ws_valid;
         if (ms_to_ws_valid && ws_allowin) begin
            ws_pc      <= ms_pc;
            ws_gr_we   <= ms_gr_we;
            ws_dest    <= ms_dest;
            ws_res     <= ms_res;
            ws_ld_op   <= ms_ld_op;
            ws_ld_data <= ms_ld_data;
         end
      end
   end

   load_extract u_load_extract (
      .ld_op   (ws_ld_op),
      .res     (ws_res),
      .ld_data (ws_ld_data),
      .result  (ws_result)
   );

   assign rf_we    = ws_valid && ws_gr_we && ws_ready_go;
   assign rf_waddr = ws_dest;
   assign rf_wdata = ws_result;

   // Bypass ignores the stall so decode keeps seeing the pending write
   assign ws_fwd_dest = (ws_valid && ws_gr_we) ? ws_dest : '0;
   assign ws_fwd_data = ws_result;

   assign debug_wb_pc       = ws_pc;
   assign debug_wb_rf_wen   = {4{rf_we}};
   assign debug_wb_rf_wnum  = ws_dest;
   assign debug_wb_rf_wdata = ws_result;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic [31:0] ms_pc;
   logic        ms_gr_we;
   logic [4:0]  ms_dest;
   logic [31:0] ms_res;
   logic [2:0]  ms_ld_op;
   logic [31:0] ms_ld_data;
   logic        trace_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  ws_fwd_dest;
   logic [31:0] ws_fwd_data;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: the instruction currently held by the stage
   logic        m_valid;
   logic [31:0] m_pc, m_res, m_data;
   logic        m_gr_we;
   logic [4:0]  m_dest;
   logic [2:0]  m_op;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ws_allowin        (ws_allowin),
      .ms_pc             (ms_pc),
      .ms_gr_we          (ms_gr_we),
      .ms_dest           (ms_dest),
      .ms_res            (ms_res),
      .ms_ld_op          (ms_ld_op),
      .ms_ld_data        (ms_ld_data),
      .trace_stall       (trace_stall),
      .rf_we             (rf_we),
      .rf_waddr          (rf_waddr),
      .rf_wdata          (rf_wdata),
      .ws_fwd_dest       (ws_fwd_dest),
      .ws_fwd_data       (ws_fwd_data),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_ld(input logic [2:0] op, input logic [31:0] res,
                                          input logic [31:0] d);
      int unsigned b, h;
      b = (d >> (8 * int'(res[1:0]))) & 32'd255;
      h = (d >> (16 * int'(res[1]))) & 32'd65535;
      case (op)
         3'd1:    return (b < 128) ? 32'(b) : 32'(b + 32'hFFFF_FF00);
         3'd2:    return 32'(b);
         3'd3:    return (h < 32768) ? 32'(h) : 32'(h + 32'hFFFF_0000);
         3'd4:    return 32'(h);
         3'd5:    return d;
         default: return res;
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_pc = '0; m_res = '0; m_data = '0;
      m_gr_we = 1'b0; m_dest = '0; m_op = '0;
   endtask

   task automatic check_model();
      logic        e_we;
      logic [31:0] e_wd;
      e_we = m_valid && m_gr_we && !trace_stall;
      e_wd = ref_ld(m_op, m_res, m_data);
      chk("allowin", 32'(ws_allowin), 32'(!m_valid || !trace_stall));
      chk("rf_we", 32'(rf_we), 32'(e_we));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_dest));
      chk("rf_wdata", rf_wdata, e_wd);
      chk("fwd_dest", 32'(ws_fwd_dest), (m_valid && m_gr_we) ? 32'(m_dest) : 32'd0);
      chk("fwd_data", ws_fwd_data, e_wd);
      chk("dbg_pc", debug_wb_pc, m_pc);
      chk("dbg_wen", 32'(debug_wb_rf_wen), e_we ? 32'hF : 32'h0);
      chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(m_dest));
      chk("dbg_wdata", debug_wb_rf_wdata, e_wd);
   endtask

   // Check at the current inputs, clock once, advance the model, return at negedge
   task automatic tick();
      #1;
      check_model();
      @(posedge clk);
      if (!m_valid || !trace_stall) begin
         m_valid = ms_to_ws_valid;
         if (ms_to_ws_valid) begin
            m_pc = ms_pc; m_gr_we = ms_gr_we; m_dest = ms_dest;
            m_res = ms_res; m_op = ms_ld_op; m_data = ms_ld_data;
         end
      end
      @(negedge clk);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] res, input logic [31:0] d,
                        input logic we, input logic [4:0] dest, input logic [31:0] pc);
      ms_to_ws_valid = 1'b1; ms_ld_op = op; ms_res = res; ms_ld_data = d;
      ms_gr_we = we; ms_dest = dest; ms_pc = pc;
   endtask

   task automatic idle();
      ms_to_ws_valid = 1'b0;
      ms_pc = $urandom; ms_res = $urandom; ms_ld_data = $urandom;
   endtask

   // Issue one instruction, then check the retiring write against a constant
   task automatic directed(input string tag, input logic [2:0] op, input logic [31:0] res,
                           input logic [31:0] d, input logic [4:0] dest, input logic [31:0] exp);
      issue(op, res, d, 1'b1, dest, 32'h0040_0000 + res);
      tick();
      idle();
      #1;
      chk({tag, "_we"}, 32'(rf_we), 32'd1);
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(dest));
      chk({tag, "_wdata"}, rf_wdata, exp);
      tick();
   endtask

   initial begin
      resetn = 1'b0; trace_stall = 1'b0; ms_to_ws_valid = 1'b0;
      ms_pc = '0; ms_gr_we = 1'b0; ms_dest = '0; ms_res = '0; ms_ld_op = '0; ms_ld_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_allowin", 32'(ws_allowin), 32'd1);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_fwd", 32'(ws_fwd_dest), 32'd0);
      chk("rst_pc", debug_wb_pc, 32'd0);
      resetn = 1'b1;

      directed("lb",   3'd1, 32'h1000_0003, 32'h80FF_1234, 5'd5, 32'hFFFF_FF80);
      directed("lbu",  3'd2, 32'h1000_0003, 32'h80FF_1234, 5'd5, 32'h0000_0080);
      directed("lh2",  3'd3, 32'h1000_0002, 32'h8001_7FFF, 5'd6, 32'hFFFF_8001);
      directed("lhu2", 3'd4, 32'h1000_0002, 32'h8001_7FFF, 5'd6, 32'h0000_8001);
      directed("lh0",  3'd3, 32'h1000_0000, 32'h8001_7FFF, 5'd6, 32'h0000_7FFF);
      directed("undef",3'd7, 32'hCAFE_0001, 32'h5555_5555, 5'd9, 32'hCAFE_0001);

      // ALU write to r31 followed back-to-back by a store
      issue(3'd0, 32'h1234_5678, 32'h0, 1'b1, 5'd31, 32'h0040_0100);
      tick();
      issue(3'd0, 32'h2000_0000, 32'h0, 1'b0, 5'd4, 32'h0040_0104);
      #1;
      chk("alu_we", 32'(rf_we), 32'd1);
      chk("alu_waddr", 32'(rf_waddr), 32'd31);
      chk("alu_wdata", rf_wdata, 32'h1234_5678);
      tick();
      idle();
      #1;
      chk("st_we", 32'(rf_we), 32'd0);
      chk("st_fwd", 32'(ws_fwd_dest), 32'd0);
      tick();

      // LW held by a 3-cycle trace stall
      issue(3'd5, 32'h1000_0001, 32'hDEAD_BEEF, 1'b1, 5'd7, 32'h0040_0200);
      tick();
      ms_gr_we = 1'b0; ms_dest = 5'd1;
      trace_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stl_allowin", 32'(ws_allowin), 32'd0);
         chk("stl_we", 32'(rf_we), 32'd0);
         chk("stl_fwd", 32'(ws_fwd_dest), 32'd7);
         tick();
      end
      trace_stall = 1'b0;
      idle();
      #1;
      chk("rel_we", 32'(rf_we), 32'd1);
      chk("rel_wdata", rf_wdata, 32'hDEAD_BEEF);
      tick();
      chk("rel_once", 32'(rf_we), 32'd0);

      // Stall while empty still accepts
      trace_stall = 1'b1;
      #1;
      chk("empty_stl_allowin", 32'(ws_allowin), 32'd1);
      trace_stall = 1'b0;

      // Asynchronous reset with a writing instruction in flight
      issue(3'd0, 32'h0BAD_0BAD, 32'h0, 1'b1, 5'd3, 32'h0040_0300);
      tick();
      idle();
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_we", 32'(rf_we), 32'd0);
      chk("arst_allowin", 32'(ws_allowin), 32'd1);
      chk("arst_fwd", 32'(ws_fwd_dest), 32'd0);
      chk("arst_pc", debug_wb_pc, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("arst_rel_we", 32'(rf_we), 32'd0);
      tick();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         ms_to_ws_valid = ($urandom_range(0, 3) != 0);
         trace_stall    = ($urandom_range(0, 3) == 0);
         ms_pc          = $urandom;
         ms_gr_we       = 1'($urandom_range(0, 1));
         ms_dest        = 5'($urandom_range(0, 31));
         ms_res         = $urandom;
         ms_ld_op       = 3'($urandom_range(0, 7));
         ms_ld_data     = $urandom;
         tick();
      end
      trace_stall = 1'b0;
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage MIPS pipeline, sitting between the memory stage and the register file write port. It latches the memory-stage result in a valid/allowin pipeline register and extracts and extends load data by load type and address byte offset. It drives the single register-file write port, exposes its destination and data to decode for bypass and hazard checks, and emits the per-instruction debug trace.

## Interface
- Parameters: none; datapath is fixed at 32 bits and register index at 5 bits.
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- ms_to_ws_valid  in  1  memory stage presents an instruction
- ws_allowin  out  1  wb_stage can accept this cycle
- ms_pc  in  32  instruction PC
- ms_gr_we  in  1  instruction writes a GPR
- ms_dest  in  5  destination GPR index
- ms_res  in  32  ALU result; for loads, the effective address
- ms_ld_op  in  3  load type (codes in package)
- ms_ld_data  in  32  raw word returned by data RAM
- trace_stall  in  1  debug trace sink cannot accept; holds the stage
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write index
- rf_wdata  out  32  write data
- ws_fwd_dest  out  5  bypass destination; 0 = no pending write
- ws_fwd_data  out  32  bypass data (= rf_wdata)
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_wen  out  4  trace byte enables; {4{rf_we}}
- debug_wb_rf_wnum  out  5  trace register index
- debug_wb_rf_wdata  out  32  trace write data

## Operation
- Internal state: ws_valid, plus payload registers pc, gr_we, dest, res, ld_op, ld_data.
- ws_ready_go = !trace_stall.
- ws_allowin = !ws_valid || ws_ready_go.
- When ws_allowin: ws_valid <= ms_to_ws_valid.
- When ms_to_ws_valid && ws_allowin: all payload registers load. Otherwise the payload holds.
- Load extraction uses the byte offset off = res[1:0]:
  - LD_NONE (000), and the undefined codes 110/111: result = res.
  - LB (001): sign-extend byte[off]. LBU (010): zero-extend byte[off].
  - LH (011): sign-extend halfword[res[1]]. LHU (100): zero-extend halfword[res[1]]. res[0] is ignored; misalignment is trapped upstream.
  - LW (101): result = ld_data; off is ignored.
- rf_we = ws_valid && gr_we && ws_ready_go. The write commits exactly once, on the cycle the instruction retires.
- rf_waddr = dest. rf_wdata = the extracted result.
- A write to dest 0 is permitted; the register file discards it on read.
- ws_fwd_dest = (ws_valid && gr_we) ? dest : 0. This holds during a stall so decode keeps seeing the hazard.
- The debug trace mirrors the rf_* outputs. debug_wb_pc = pc.

## Timing
- Reset, asynchronous on resetn low: ws_valid = 0 and all payload registers = 0. Outputs are therefore rf_we = 0, rf_waddr = 0, rf_wdata = 0, ws_fwd_dest = 0, debug_wb_rf_wen = 0, debug_wb_pc = 0, and ws_allowin = 1.
- Latency: an instruction accepted at edge N drives rf_we in cycle N..N+1. The register file captures it at edge N+1, provided trace_stall is low.
- Back-to-back: with trace_stall low, the stage accepts one instruction per cycle and each retires the following cycle.
- Stall with ws_valid = 1 and trace_stall = 1:
  - ws_allowin = 0 and the payload holds.
  - rf_we = 0; the stalled instruction is not written until trace_stall falls.
  - Upstream must hold its payload.
- Stall while empty: ws_allowin = 1, so the stage still accepts.
- Retire and accept in the same cycle: the old instruction writes and the new payload loads at the same edge.
- resetn asserted mid-operation: the in-flight instruction is dropped with no write, and all outputs return to reset values immediately.

## Structure
- Shared package mips_pkg holds:
  - LD_NONE/LB/LBU/LH/LHU/LW 3-bit codes
  - REG_IDX_W = 5, DATA_W = 32
- One natural sub-module: load_extract. It is combinational (ld_op, off, ld_data -> result) and reusable by a future bypass path.
- The pipeline register and handshake live in wb_stage itself.

## Test plan
- LB at off=3, ld_data=0x80FF_1234, dest=5 -> rf_we=1, rf_waddr=5, rf_wdata=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- LH at res=0x...2, ld_data=0x8001_7FFF -> 0xFFFF_8001. LHU -> 0x0000_8001. LH at res=0x...0 -> 0x0000_7FFF.
- ALU op, res=0x1234_5678, gr_we=1, dest=31, followed back-to-back by a store (gr_we=0) -> one write of 0x1234_5678 to r31. In the next cycle rf_we=0 and ws_fwd_dest=0.
- Assert trace_stall for 3 cycles with a valid LW (data 0xDEAD_BEEF, dest 7):
  - ws_allowin=0, rf_we=0, ws_fwd_dest=7 throughout.
  - After release, exactly one write of 0xDEAD_BEEF.
- resetn low while ws_valid=1 and gr_we=1 -> rf_we drops to 0 immediately, ws_allowin=1, and no write occurs after release.
- Undefined ld_op 3'b111, res=0xCAFE_0001 -> rf_wdata=0xCAFE_0001.
